// File: rtl/cpu_seq_if.sv
// Fetch and ALU bus between the sequencer (master) and its memory/ALU neighbours (slave).
interface cpu_seq_if #(
  parameter int unsigned PC_W = 8
) ();
  // Instruction fetch handshake
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic [15:0]     imem_rdata;
  logic            imem_ack;

  // ALU operands and opcode out, result and flags back
  logic [15:0]     alu_rd;
  logic [15:0]     alu_rs;
  logic [3:0]      alu_opcode;
  logic [3:0]      alu_immd;
  logic [15:0]     alu_result;
  logic            alu_carry;
  logic            alu_overflow;
  logic            alu_minus;
  logic            alu_zero;

  modport master (
    output imem_addr, imem_req, alu_rd, alu_rs, alu_opcode, alu_immd,
    input  imem_rdata, imem_ack, alu_result, alu_carry, alu_overflow, alu_minus, alu_zero
  );

  modport slave (
    input  imem_addr, imem_req, alu_rd, alu_rs, alu_opcode, alu_immd,
    output imem_rdata, imem_ack, alu_result, alu_carry, alu_overflow, alu_minus, alu_zero
  );
endinterface

// File: rtl/cpu_seq.sv
// Multi-cycle sequencer with a 16x16 register file. Fetches over a req/ack handshake,
// feeds the external ALU, writes results back, and executes LDI/BZ/JMP/NOP/HLT locally.
module cpu_seq #(
  parameter int unsigned PC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  cpu_seq_if.master   bus,
  output logic [3:0]  flags,
  output logic        instr_done,
  output logic        halted,
  input  logic [3:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  localparam logic [3:0] OpCmp = 4'h5;
  localparam logic [3:0] OpNop = 4'h7;
  localparam logic [3:0] OpLdi = 4'hC;
  localparam logic [3:0] OpBz  = 4'hD;
  localparam logic [3:0] OpJmp = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [15:0]     opd_q;
  logic [15:0]     ops_q;
  logic [15:0]     res_q;
  logic [3:0]      flags_q;
  logic [3:0]      alu_op_q;
  logic [3:0]      alu_immd_q;
  logic            req_q;
  logic            done_q;
  logic            halted_q;
  logic [15:0]     regs_q [16];

  logic [3:0] ir_op;
  logic [3:0] ir_rd;
  logic [3:0] ir_rs;
  logic [7:0] ir_imm8;

  assign ir_op   = ir_q[15:12];
  assign ir_rd   = ir_q[11:8];
  assign ir_rs   = ir_q[7:4];
  assign ir_imm8 = ir_q[7:0];

  // Everything outside {NOP, LDI, BZ, JMP, HLT} goes through the ALU
  function automatic logic is_alu(input logic [3:0] op);
    return !(op inside {OpNop, OpLdi, OpBz, OpJmp, OpHlt});
  endfunction

  // Sequencer FSM, register file and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      ir_q       <= '0;
      opd_q      <= '0;
      ops_q      <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      alu_op_q   <= '0;
      alu_immd_q <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      halted_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          req_q   <= 1'b1;
          state_q <= StFetch;
        end
        StFetch: begin
          if (bus.imem_ack) begin
            ir_q    <= bus.imem_rdata;
            pc_q    <= pc_q + PC_W'(1);
            req_q   <= 1'b0;
            state_q <= StDecode;
            // Local ops retire in DECODE, so the pulse is armed from the fetched word
            done_q  <= !is_alu(bus.imem_rdata[15:12]);
          end
        end
        StDecode: begin
          if (is_alu(ir_op)) begin
            opd_q      <= regs_q[ir_rd];
            ops_q      <= regs_q[ir_rs];
            alu_op_q   <= ir_op;
            alu_immd_q <= ir_q[3:0];
            state_q    <= StExec;
          end else begin
            case (ir_op)
              OpLdi:   regs_q[ir_rd] <= {8'h00, ir_imm8};
              // pc already holds the next address here
              OpBz:    if (flags_q[0]) pc_q <= pc_q + PC_W'($signed(ir_imm8));
              OpJmp:   pc_q <= PC_W'(ir_imm8);
              default: ;
            endcase
            if (ir_op == OpHlt) begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end else begin
              req_q   <= 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StExec: begin
          if (alu_op_q != OpCmp) res_q <= bus.alu_result;
          flags_q <= {bus.alu_carry, bus.alu_overflow, bus.alu_minus, bus.alu_zero};
          done_q  <= 1'b1;
          state_q <= StWb;
        end
        StWb: begin
          if (alu_op_q != OpCmp) regs_q[ir_rd] <= res_q;
          req_q   <= 1'b1;
          state_q <= StFetch;
        end
        StHalt: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.imem_req   = req_q;
  assign bus.alu_rd     = opd_q;
  assign bus.alu_rs     = ops_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_immd   = alu_immd_q;
  assign flags          = flags_q;
  assign instr_done     = done_q;
  assign halted         = halted_q;
  assign dbg_data       = regs_q[dbg_sel];

endmodule

// File: tb/tb_cpu_seq.sv
// Scoreboard bench for cpu_seq: an ISA-level model steps on every delivered instruction and
// queues the expected retirement; a monitor checks each instr_done against the queue.
module tb_cpu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  flags;
  logic        instr_done;
  logic        halted;
  logic [3:0]  dbg_sel;
  logic [15:0] dbg_data;

  cpu_seq_if #(.PC_W(8)) bus ();

  cpu_seq #(.PC_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master),
    .flags      (flags),
    .instr_done (instr_done),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // External ALU behaviour: returns {C, V, N, Z, result}
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] sh);
    logic [16:0] w;
    logic [15:0] r;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (op)
      4'h0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'h1, 4'h5: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[15:0];
        c = w[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h6: r = b;
      4'h8: r = a << sh;
      4'h9: r = (a << sh) | (a >> (5'd16 - {1'b0, sh}));
      4'hA: r = a >> sh;
      4'hB: r = $unsigned($signed(a) >>> sh);
      default: r = 16'hDEAD;
    endcase
    return {c, v, r[15], (r == 16'h0000), r};
  endfunction

  assign {bus.alu_carry, bus.alu_overflow, bus.alu_minus, bus.alu_zero, bus.alu_result} =
    alu_fn(bus.alu_opcode, bus.alu_rd, bus.alu_rs, bus.alu_immd);

  // Instruction memory and architectural reference state
  logic [15:0] mem [256];
  logic [15:0] m_regs [16];
  logic [3:0]  m_flags;
  logic [7:0]  m_pc;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] val;
    logic [3:0]  flg;
    logic [7:0]  pc;
    bit          halt;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  // Execute one instruction at the ISA level and queue what its retirement must show
  task automatic model_step(input int waits);
    logic [15:0] ins;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [19:0] fr;
    exp_t        e;
    ins  = mem[m_pc];
    op   = ins[15:12];
    rd   = ins[11:8];
    m_pc = m_pc + 8'd1;
    e.halt = 1'b0;
    e.lat  = waits + 2;
    case (op)
      4'h7: ;
      4'hC: m_regs[rd] = {8'h00, ins[7:0]};
      4'hD: if (m_flags[0]) m_pc = m_pc + ins[7:0];
      4'hE: m_pc = ins[7:0];
      4'hF: e.halt = 1'b1;
      default: begin
        fr      = alu_fn(op, m_regs[rd], m_regs[ins[7:4]], ins[3:0]);
        m_flags = fr[19:16];
        if (op != 4'h5) m_regs[rd] = fr[15:0];
        e.lat = waits + 4;
      end
    endcase
    e.rd  = rd;
    e.val = m_regs[rd];
    e.flg = m_flags;
    e.pc  = m_pc;
    exp_q.push_back(e);
  endtask

  // Memory responder: random wait states, random ack noise outside fetch
  int          wait_lo = 0;
  int          wait_hi = 0;
  int          wait_left = -1;
  int          waits_used = 0;
  logic [7:0]  req_addr;

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.imem_ack = 1'b0;
        wait_left    = -1;
      end else if (bus.imem_req) begin
        if (wait_left < 0) begin
          wait_left  = $urandom_range(wait_hi, wait_lo);
          waits_used = wait_left;
          req_addr   = bus.imem_addr;
        end else begin
          check("addr_stable", {24'h0, bus.imem_addr}, {24'h0, req_addr});
        end
        if (wait_left == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr];
          model_step(waits_used);
          wait_left = -1;
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = 16'($urandom);
          wait_left--;
        end
      end else begin
        bus.imem_ack   = ($urandom_range(0, 3) == 0);
        bus.imem_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: pop on every retirement, check state on the following cycle
  bit   mon_en = 1'b0;
  bit   pending = 1'b0;
  bit   have_prev = 1'b0;
  int   cyc = 0;
  int   prev_cyc = 0;
  int   retired = 0;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (pending) begin
          check("reg_rd", {16'h0, dbg_data}, {16'h0, cur.val});
          check("flags", {28'h0, flags}, {28'h0, cur.flg});
          if (cur.halt) begin
            check("halted", {31'h0, halted}, 32'd1);
            check("halt_req", {31'h0, bus.imem_req}, 32'd0);
          end else begin
            check("next_req", {31'h0, bus.imem_req}, 32'd1);
            check("next_pc", {24'h0, bus.imem_addr}, {24'h0, cur.pc});
          end
          pending = 1'b0;
        end
        if (instr_done) begin
          if (exp_q.size() == 0) begin
            check("retire_unexpected", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            if (have_prev) check("latency", cyc - prev_cyc, cur.lat);
            dbg_sel = cur.rd;
            pending = 1'b1;
            retired++;
          end
          have_prev = 1'b1;
          prev_cyc  = cyc;
        end
      end
    end
  end

  // Hold reset, verify the reset state of every register, then release with a clean model
  task automatic do_reset();
    mon_en = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      @(negedge clk);
      check("rst_reg", {16'h0, dbg_data}, 32'd0);
      check("rst_req", {31'h0, bus.imem_req}, 32'd0);
    end
    check("rst_flags", {28'h0, flags}, 32'd0);
    check("rst_halted", {31'h0, halted}, 32'd0);
    check("rst_done", {31'h0, instr_done}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_flags   = '0;
    m_pc      = '0;
    pending   = 1'b0;
    have_prev = 1'b0;
    retired   = 0;
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    #1;
    check("idle_req", {31'h0, bus.imem_req}, 32'd0);
  endtask

  task automatic wait_retired(input int n, input int budget);
    int k;
    k = 0;
    while (retired < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (retired < n) check("retire_timeout", retired, n);
  endtask

  task automatic fill_hlt();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic load_prog_a();
    fill_hlt();
    mem[8'h00] = 16'hC105;  // LDI r1,05
    mem[8'h01] = 16'hC203;  // LDI r2,03
    mem[8'h02] = 16'h1120;  // SUB r1,r2
    mem[8'h03] = 16'hC307;  // LDI r3,07
    mem[8'h04] = 16'hC407;  // LDI r4,07
    mem[8'h05] = 16'h5340;  // CMP r3,r4 -> Z=1
    mem[8'h06] = 16'hD002;  // BZ +2 -> 09
    mem[8'h09] = 16'hC408;  // LDI r4,08
    mem[8'h0A] = 16'h5340;  // CMP r3,r4 -> Z=0
    mem[8'h0B] = 16'hD002;  // BZ +2 not taken -> 0C
    mem[8'h0C] = 16'hE0FF;  // JMP FF
    mem[8'hFF] = 16'h7000;  // NOP -> wraps to 00
  endtask

  initial begin
    rst     = 1'b1;
    dbg_sel = '0;

    // Directed program, zero-wait ack; first fetch right after release
    load_prog_a();
    wait_lo = 0;
    wait_hi = 0;
    do_reset();
    @(negedge clk);
    check("first_req", {31'h0, bus.imem_req}, 32'd1);
    check("first_addr", {24'h0, bus.imem_addr}, 32'd0);
    wait_retired(15, 300);

    // Same program with every fetch stalled three cycles
    wait_lo = 3;
    wait_hi = 3;
    do_reset();
    wait_retired(15, 500);

    // Halt is terminal
    fill_hlt();
    mem[8'h00] = 16'hC55A;
    mem[8'h01] = 16'hF000;
    wait_lo = 0;
    wait_hi = 2;
    do_reset();
    wait_retired(2, 100);
    repeat (20) begin
      @(negedge clk);
      check("halt_hold", {30'h0, halted, bus.imem_req}, 32'd2);
    end

    // Reset during EXEC of ADD must drop the writeback
    fill_hlt();
    mem[8'h00] = 16'hC105;
    mem[8'h01] = 16'hC203;
    mem[8'h02] = 16'h0120;
    wait_lo = 0;
    wait_hi = 0;
    do_reset();
    begin
      int k;
      k = 0;
      while (!(bus.alu_rd == 16'd5 && bus.alu_rs == 16'd3) && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("reach_exec", {31'h0, (bus.alu_rd == 16'd5 && bus.alu_rs == 16'd3)}, 32'd1);
    end
    rst = 1'b1;
    dbg_sel = 4'd1;
    #1;
    check("abort_r1", {16'h0, dbg_data}, 32'd0);
    do_reset();

    // Random programs with random wait states
    for (int i = 0; i < 256; i++) begin
      mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    end
    wait_lo = 0;
    wait_hi = 2;
    do_reset();
    wait_retired(400, 4000);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_seq.md
# cpu_seq

Multi-cycle sequencer and register file that sits directly upstream and downstream of the ALU. It fetches 16-bit instructions from instruction memory over a req/ack handshake, decodes them, and presents operands, opcode and shift immediate to the ALU. It then captures the ALU result and flags and writes the result back into a 16×16 register file. It also executes the non-ALU instructions itself: LDI, BZ, JMP, NOP and HLT.

## Interface
- PC_W, 8, program counter / instruction address width; legal range 8..16
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  PC_W  fetch address (= pc)
- imem_req  out  1  fetch request
- imem_rdata  in  16  instruction word; sampled on the cycle imem_ack=1 while imem_req=1
- imem_ack  in  1  fetch complete
- alu_rd  out  16  ALU first operand (reg[rd])
- alu_rs  out  16  ALU second operand (reg[rs])
- alu_opcode  out  4  ir[15:12]
- alu_immd  out  4  ir[3:0]
- alu_result  in  16  ALU result
- alu_carry, alu_overflow, alu_minus, alu_zero  in  1 each  ALU flags
- flags  out  4  {C,V,N,Z} flag register
- instr_done  out  1  one-cycle pulse in the last cycle of every retired instruction
- halted  out  1  high while in HALT
- dbg_sel  in  4  register select
- dbg_data  out  16  reg[dbg_sel], combinational

## Operation
- Instruction format: [15:12] op, [11:8] rd, [7:4] rs, [3:0] immd; imm8 = [7:0].
- ALU ops:
  - 0000 ADD, 0001 SUB (rd−rs), 0010 AND, 0011 OR, 0100 XOR, 0110 MOV, 1000 SLL, 1001 ROL, 1010 SRL, 1011 SRA: write alu_result to rd and update flags.
  - 0101 CMP: update flags only, no write.
- Local ops, handled without the ALU:
  - 1100 LDI: rd ← {8'h00, imm8}.
  - 1101 BZ: if Z=1, pc ← pc_next + sext(imm8), mod 2^PC_W.
  - 1110 JMP: pc ← zext/truncate(imm8).
  - 0111 NOP.
  - 1111 HLT.
  - Local ops never change flags.
- State machine:
  - Reset enters IDLE.
  - IDLE → FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=pc. Wait for ack. On ack: ir ← imem_rdata, pc ← pc+1 (wraps to 0), go to DECODE.
  - DECODE:
    - ALU ops: latch operand registers opd ← reg[rd], ops ← reg[rs]; go to EXEC.
    - LDI: write rd.
    - BZ / JMP: update pc.
    - NOP: no action.
    - LDI, BZ, JMP and NOP then pulse instr_done and go to FETCH.
    - HLT: pulse instr_done, go to HALT.
  - EXEC: alu_* driven from opd/ops/ir. Latch res ← alu_result and the flag inputs (except CMP, which latches flags only). Go to WB.
  - WB: write res to reg[rd] (skip for CMP). Pulse instr_done, go to FETCH.
  - HALT: terminal; imem_req=0; exit only by rst.
- alu_rd / alu_rs / alu_opcode / alu_immd are stable from EXEC entry through WB.
- In other states they hold their last values.
- Register file: one write port, two internal read ports plus the dbg port. r0 is an ordinary register.

## Timing
- Reset values: pc=0, all regs=0, flags=0, ir=0, opd=ops=res=0, imem_req=0, instr_done=0, halted=0, state IDLE.
- First imem_req=1 with imem_addr=0 occurs on the first cycle after rst deasserts.
- imem_req stays high and imem_addr stays stable until ack. An ack in the same cycle as req is legal.
- imem_ack outside FETCH is ignored.
- Latency with zero-wait ack:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Local op: 2 cycles.
  - Each ack wait cycle adds 1.
- Register or flag writes from instruction N are visible to the DECODE of instruction N+1. No forwarding is needed.
- dbg_data reflects a write on the cycle after the writing edge.
- rst asserted in any state aborts immediately: no pending write, no pc update, all state reset.

## Test plan
- Reset / first fetch: hold rst 3 cycles, then release → imem_req=0 during reset; req=1 with addr=0x00 one cycle after release; all dbg_data=0, flags=0.
- Arithmetic writeback: LDI r1,0x05; LDI r2,0x03; SUB r1,r2 (0x1120) → r1=0x0002, Z=0, N=0. instr_done pulses 3 times over 8 cycles with zero-wait ack.
- Compare and branch: LDI r3,0x07; LDI r4,0x07; CMP r3,r4 → Z=1, r3 unchanged. Then BZ +2 at addr 3 → next imem_addr=0x06. With r4=0x08 instead, Z=0 and the next addr is 0x04.
- Fetch stall: delay imem_ack 3 cycles → imem_addr and imem_req stable; ir, pc and regs unchanged; instruction retires exactly 3 cycles later than with zero-wait ack.
- PC wrap / JMP: JMP 0xFF; NOP at 0xFF → next imem_addr=0x00.
- Halt and mid-op reset:
  - HLT → halted=1 and imem_req=0 indefinitely.
  - Separately, assert rst during EXEC of ADD r1,r2 → r1 remains 0 after reset.
